// File: rtl/f1_reaction_timer.sv
// F1 reaction timer: waits a pseudo-random delay after the last start light,
// pulses lights_out, then measures the time in ticks until the driver's trigger.
// Optional feature macro: F1_BEST_TIME_EN (tracks the best valid reaction time).
module f1_reaction_timer #(
  parameter int unsigned MIN_DELAY_MS  = 500,
  parameter int unsigned DELAY_STEP_MS = 20,
  parameter int unsigned MAX_MS        = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        cmd_seq,
  input  logic        cmd_delay,
  input  logic        trigger,
  output logic        lights_out,
  output logic        wait_active,
  output logic        measuring,
  output logic [13:0] react_ms,
  output logic        react_valid,
  output logic        false_start,
  output logic        timeout,
  output logic [13:0] best_ms
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_MEASURE,
    S_DONE,
    S_FALSE
  } state_t;

  localparam logic [13:0] MAX14 = 14'(MAX_MS);

  state_t      state, state_n;
  logic        cmd_seq_q;
  logic        seq_rise;
  logic [6:0]  lfsr;
  logic [15:0] delay_cnt, delay_n;
  logic [15:0] delay_load;
  logic [13:0] count, count_n;
  logic [13:0] count_inc;
  logic [13:0] react_n;
  logic        valid_n, false_n, timeout_n, lo_n;

  assign seq_rise   = cmd_seq & ~cmd_seq_q;
  assign delay_load = 16'(MIN_DELAY_MS) + 16'(lfsr) * 16'(DELAY_STEP_MS);
  assign count_inc  = count + 14'd1;

  // State register, edge-detect flop, LFSR and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_seq_q   <= 1'b0;
      lfsr        <= 7'h01;
      delay_cnt   <= '0;
      count       <= '0;
      lights_out  <= 1'b0;
      wait_active <= 1'b0;
      measuring   <= 1'b0;
      react_ms    <= '0;
      react_valid <= 1'b0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_seq_q   <= cmd_seq;
      lfsr        <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      delay_cnt   <= delay_n;
      count       <= count_n;
      lights_out  <= lo_n;
      wait_active <= (state_n == S_DELAY);
      measuring   <= (state_n == S_MEASURE);
      react_ms    <= react_n;
      react_valid <= valid_n;
      false_start <= false_n;
      timeout     <= timeout_n;
    end
  end

  // Next-state and next-output logic; trigger outranks tick in every state
  always_comb begin
    state_n   = state;
    delay_n   = delay_cnt;
    count_n   = count;
    react_n   = react_ms;
    valid_n   = react_valid;
    false_n   = false_start;
    timeout_n = timeout;
    lo_n      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_FALSE: begin
        if (seq_rise) begin
          state_n   = S_ARMED;
          valid_n   = 1'b0;
          false_n   = 1'b0;
          timeout_n = 1'b0;
        end
      end
      S_ARMED: begin
        if (trigger) begin
          state_n = S_FALSE;
          false_n = 1'b1;
          valid_n = 1'b0;
        end else if (cmd_delay) begin
          state_n = S_DELAY;
          delay_n = delay_load;
        end
      end
      S_DELAY: begin
        if (trigger) begin
          state_n = S_FALSE;
          false_n = 1'b1;
          valid_n = 1'b0;
        end else if (tick) begin
          if (delay_cnt <= 16'd1) begin
            state_n = S_MEASURE;
            lo_n    = 1'b1;
            count_n = '0;
            delay_n = '0;
          end else begin
            delay_n = delay_cnt - 16'd1;
          end
        end
      end
      S_MEASURE: begin
        if (trigger) begin
          state_n = S_DONE;
          react_n = count;
          valid_n = 1'b1;
        end else if (tick) begin
          if (count_inc >= MAX14) begin
            state_n   = S_DONE;
            count_n   = MAX14;
            react_n   = MAX14;
            valid_n   = 1'b1;
            timeout_n = 1'b1;
          end else begin
            count_n = count_inc;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef F1_BEST_TIME_EN
  // Best time: only a triggered (non-timeout) DONE entry can improve it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      best_ms <= 14'h3FFF;
    else if (state == S_MEASURE && trigger && count < best_ms)
      best_ms <= count;
  end
`else
  assign best_ms = 14'h3FFF;
`endif

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Self-checking bench for f1_reaction_timer: table of scenarios, hand-written
// reset/best-time sequence, and randomized runs against a scenario-level model.
module tb_f1_reaction_timer;

  logic        clk = 1'b0;
  logic        rst, tick, cmd_seq, cmd_delay, trigger;
  logic        lights_out, wait_active, measuring;
  logic [13:0] react_ms, best_ms;
  logic        react_valid, false_start, timeout;

  f1_reaction_timer #(.MIN_DELAY_MS(5), .DELAY_STEP_MS(0), .MAX_MS(50)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay),
    .trigger(trigger), .lights_out(lights_out), .wait_active(wait_active),
    .measuring(measuring), .react_ms(react_ms), .react_valid(react_valid),
    .false_start(false_start), .timeout(timeout), .best_ms(best_ms)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;      // 0 = trigger after n ticks in MEASURE, 1 = false start
    int n;
    bit coin;      // trigger coincides with a tick
    int er;
    bit ev, ef, et;
  } vec_t;

  int tests = 0, fails = 0;
  int phase = 0, ticks = 0;
  bit lo_seen = 0;
  int exp_best, prev_react;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one clock; tick every 4th cycle; inputs change #1 after the edge
  task automatic clk1();
    tick = (phase == 3);
    @(posedge clk);
    #1;
    if (tick) ticks++;
    phase = (phase + 1) % 4;
    if (lights_out) lo_seen = 1;
  endtask

  task automatic update_best(input int r);
`ifdef F1_BEST_TIME_EN
    if (r < exp_best) exp_best = r;
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_lights_out"}, lights_out, 0);
    chk({tag, "_wait_active"}, wait_active, 0);
    chk({tag, "_measuring"}, measuring, 0);
    chk({tag, "_react_ms"}, react_ms, 0);
    chk({tag, "_react_valid"}, react_valid, 0);
    chk({tag, "_false_start"}, false_start, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_best_ms"}, best_ms, 14'h3FFF);
  endtask

  task automatic arm();
    cmd_seq = 1; clk1();
    chk("arm_flags", {react_valid, false_start, timeout}, 0);
    chk("arm_wait", wait_active, 0);
    clk1();
    cmd_delay = 1; clk1();
    cmd_delay = 0; cmd_seq = 0;
    chk("delay_wait_active", wait_active, 1);
    ticks = 0;
    lo_seen = 0;
  endtask

  task automatic run(input int mode, input int n, input bit coin,
                     input int er, input bit ev, input bit ef, input bit et);
    int guard;
    arm();
    if (mode == 1) begin
      guard = 0;
      while (ticks < 2 && guard < 100) begin clk1(); guard++; end
      trigger = 1; clk1(); trigger = 0;
      repeat (30) clk1();
      chk("fs_lights_out_seen", lo_seen, 0);
    end else begin
      guard = 0;
      while (!lights_out && guard < 200) begin clk1(); guard++; end
      chk("lights_out_ticks", ticks, 5);
      ticks = 0;
      clk1();
      chk("lights_out_width", lights_out, 0);
      chk("measuring", measuring, 1);
      guard = 0;
      while (ticks < n && measuring && guard < 2000) begin clk1(); guard++; end
      if (measuring) begin
        if (coin) begin
          while (phase != 3) clk1();
        end else begin
          repeat ($urandom_range(0, 2)) clk1();
        end
        trigger = 1; clk1(); trigger = 0;
      end else begin
        chk("timeout_ticks", ticks, 50);
      end
      chk("measuring_done", measuring, 0);
    end
    chk("react_ms", react_ms, er);
    chk("react_valid", react_valid, ev);
    chk("false_start", false_start, ef);
    chk("timeout", timeout, et);
    if (ev && !et) update_best(er);
    chk("best_ms", best_ms, exp_best);
    // result must hold, even with a stray trigger, until the next cmd_seq edge
    trigger = 1; clk1(); trigger = 0;
    repeat (8) clk1();
    chk("hold", {react_ms, react_valid, false_start, timeout},
        {er[13:0], ev, ef, et});
    prev_react = er;
  endtask

  vec_t tbl[4];
  int n, er;
  bit ev, ef, et;

  initial begin
    tbl[0] = '{0, 37, 0, 37, 1, 0, 0};
    tbl[1] = '{1, 0, 0, 37, 0, 1, 0};
    tbl[2] = '{0, 999, 0, 50, 1, 0, 1};
    tbl[3] = '{0, 12, 1, 12, 1, 0, 0};

    tick = 0; cmd_seq = 0; cmd_delay = 0; trigger = 0;
    rst = 1;
    repeat (3) clk1();
    check_reset_outputs("reset");
    rst = 0;
    exp_best = 14'h3FFF;
    prev_react = 0;
    clk1();

    foreach (tbl[i])
      run(tbl[i].mode, tbl[i].n, tbl[i].coin, tbl[i].er, tbl[i].ev, tbl[i].ef, tbl[i].et);

    // reset in the middle of DELAY aborts with no pulse and no result
    arm();
    while (ticks < 2) clk1();
    rst = 1;
    #2;
    check_reset_outputs("midrst");
    clk1(); clk1();
    chk("midrst_no_pulse", lo_seen, 0);
    rst = 0;
    exp_best = 14'h3FFF;
    prev_react = 0;
    clk1();
    run(0, 40, 0, 40, 1, 0, 0);
    run(0, 25, 0, 25, 1, 0, 0);
    run(0, 30, 1, 30, 1, 0, 0);
`ifdef F1_BEST_TIME_EN
    chk("best_of_three", best_ms, 25);
`else
    chk("best_tied", best_ms, 14'h3FFF);
`endif

    // randomized runs against the scenario model
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        run(1, 0, 0, prev_react, 0, 1, 0);
      end else begin
        n  = $urandom_range(1, 60);
        er = (n >= 50) ? 50 : n;
        et = (n >= 50);
        run(0, n, 1'($urandom_range(0, 1)), er, 1, 0, et);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
